// File: rtl/dma_transfer_if.sv
// I/O-side capture handshake and system-bus write port of the DMA data stage.
// master = DMA data stage, slave = I/O device / handshake checker / bus model.
interface dma_transfer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [DATA_W-1:0] io_data;
    logic              recibir;
    logic              enviar;
    logic              sel;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data;
    logic              bus_we;

    modport master (
        input  io_data, recibir, enviar, sel,
        output bus_addr, bus_data, bus_we
    );

    modport slave (
        output io_data, recibir, enviar, sel,
        input  bus_addr, bus_data, bus_we
    );
endinterface

// File: rtl/dma_transfer.sv
// DMA data stage: buffers I/O words in a small FIFO and writes them to memory at an
// auto-incrementing address once the bus is granted, pulsing done at the end.
module dma_transfer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_count,
    dma_transfer_if.master    bus,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, WRITE, DONE} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       cnt_q, cnt_d;
    logic              full_q, empty_q, ovf_q;
    logic [ADDR_W-1:0] addr_q, rem_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_data_q;
    logic              bus_we_q, busy_q, done_q;

    logic pop, push, drop, cfg_ok;

    assign pop    = (state_q == ARMED) && bus.enviar && bus.sel && !empty_q;
    // A full FIFO still takes a word when the head leaves on the same edge.
    assign push   = bus.recibir && (!full_q || pop);
    assign drop   = bus.recibir && full_q && !pop;
    assign cfg_ok = (state_q == IDLE) && cfg_we;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + (PW+1)'(1);
        else if (pop && !push)
            cnt_d = cnt_q - (PW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == (PW+1)'(DEPTH));
            empty_q <= (cnt_d == '0);
            // A drop on the same edge as a new descriptor is still reported.
            if (drop)
                ovf_q <= 1'b1;
            else if (cfg_ok)
                ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.io_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            bus_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            bus_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_we) begin
                        if (cfg_count != '0) begin
                            addr_q  <= cfg_base;
                            rem_q   <= cfg_count;
                            busy_q  <= 1'b1;
                            state_q <= ARMED;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                ARMED: begin
                    if (pop) begin
                        bus_we_q   <= 1'b1;
                        bus_addr_q <= addr_q;
                        bus_data_q <= mem_q[rd_ptr_q];
                        state_q    <= WRITE;
                    end
                end
                WRITE: begin
                    addr_q <= addr_q + ADDR_W'(1);
                    rem_q  <= rem_q - ADDR_W'(1);
                    if (rem_q == ADDR_W'(1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= ARMED;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.bus_addr = bus_addr_q;
    assign bus.bus_data = bus_data_q;
    assign bus.bus_we   = bus_we_q;
    assign fifo_full    = full_q;
    assign fifo_empty   = empty_q;
    assign overflow     = ovf_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_dma_transfer.sv
// Bench for dma_transfer: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based transaction model of the FIFO and descriptor.
module tb_dma_transfer;
    localparam int DW = 8, AW = 8, DEPTH = 4;

    logic          clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0;
    logic [AW-1:0] cfg_base = '0, cfg_count = '0;
    logic          fifo_full, fifo_empty, busy, done, overflow;

    dma_transfer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    dma_transfer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_base(cfg_base),
        .cfg_count(cfg_count), .bus(bus.master), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs as seen by the DUT on the last rising edge.
    logic          c_cfg = 0, c_push = 0, c_grant = 0;
    logic [AW-1:0] c_base = '0, c_cnt = '0;
    logic [DW-1:0] c_data = '0;

    always @(posedge clk) begin
        c_cfg   <= cfg_we;
        c_base  <= cfg_base;
        c_cnt   <= cfg_count;
        c_push  <= bus.recibir;
        c_data  <= bus.io_data;
        c_grant <= bus.enviar & bus.sel;
    end

    // Transaction model: words in the FIFO, active descriptor, expected done/overflow.
    logic [DW-1:0] q[$];
    bit            active = 0, last_wr = 0, done_prev = 0, ovf_exp = 0, prev_we = 0;
    int            wr_left = 0, n_writes = 0;
    logic [AW-1:0] exp_addr = '0, last_waddr = '0;
    logic [DW-1:0] last_wdata = '0;

    always @(negedge clk) begin
        bit acc, dcur;
        if (!rst_n) begin
            q.delete();
            active = 0; last_wr = 0; done_prev = 0; ovf_exp = 0; prev_we = 0; wr_left = 0;
        end else begin
            acc  = c_cfg && !active && !done_prev;
            dcur = 0;
            if (last_wr) begin
                active = 0; dcur = 1; last_wr = 0;
            end else if (acc) begin
                ovf_exp = 0;
                if (c_cnt == 0) dcur = 1;
                else begin active = 1; exp_addr = c_base; wr_left = int'(c_cnt); end
            end
            if (bus.bus_we) begin
                chk("we_while_active", active, 1);
                chk("we_after_grant", c_grant, 1);
                chk("we_spacing", prev_we, 0);
                if (q.size() == 0) chk("we_from_empty", 0, 1);
                else chk("wdata", bus.bus_data, q.pop_front());
                chk("waddr", bus.bus_addr, exp_addr);
                last_waddr = bus.bus_addr;
                last_wdata = bus.bus_data;
                exp_addr++;
                wr_left--;
                n_writes++;
                if (wr_left == 0) last_wr = 1;
            end
            if (c_push) begin
                if (q.size() < DEPTH) q.push_back(c_data);
                else ovf_exp = 1;
            end
            chk("fifo_full", fifo_full, q.size() == DEPTH);
            chk("fifo_empty", fifo_empty, q.size() == 0);
            chk("overflow", overflow, ovf_exp);
            chk("done", done, dcur);
            chk("busy", busy, active);
            prev_we   = bus.bus_we;
            done_prev = dcur;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic grant(input logic g);
        bus.enviar = g; bus.sel = g;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0; cfg_we = 0; bus.recibir = 0; grant(0);
        #1;
        chk("rst_bus_we", bus.bus_we, 0);
        chk("rst_bus_addr", bus.bus_addr, 0);
        chk("rst_bus_data", bus.bus_data, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic cfg(input logic [AW-1:0] b, input logic [AW-1:0] c);
        cfg_we = 1; cfg_base = b; cfg_count = c;
        tick();
        cfg_we = 0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        bus.recibir = 1; bus.io_data = d;
        tick();
        bus.recibir = 0;
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while ((active || done_prev) && k < bound) begin tick(); k++; end
        chk("idle_timeout", k < bound, 1);
    endtask

    task automatic wait_we(input int bound);
        int k = 0;
        while (!bus.bus_we && k < bound) begin tick(); k++; end
        chk("we_timeout", bus.bus_we, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n0;
        bus.io_data = '0; bus.recibir = 0; grant(0);
        do_reset();
        tick(2);

        // Basic transfer
        n0 = n_writes;
        cfg(8'h10, 8'd3);
        grant(1);
        push(8'hA1); push(8'hA2); push(8'hA3);
        wait_idle(50);
        chk("basic_nwr", n_writes - n0, 3);
        chk("basic_last_addr", last_waddr, 8'h12);
        chk("basic_last_data", last_wdata, 8'hA3);
        grant(0);

        // Overflow: five pushes into a four-entry FIFO with no grant
        for (int i = 1; i <= 4; i++) push(8'(i));
        chk("ovf_full4", fifo_full, 1);
        chk("ovf_none_yet", overflow, 0);
        push(8'h05);
        chk("ovf_set", overflow, 1);
        n0 = n_writes;
        cfg(8'h30, 8'd4);
        grant(1);
        wait_idle(50);
        chk("ovf_nwr", n_writes - n0, 4);
        chk("ovf_last_data", last_wdata, 8'h04);
        chk("ovf_drained", fifo_empty, 1);
        grant(0);

        // Full FIFO, pop and push on the same edge
        do_reset();
        cfg(8'h40, 8'd5);
        for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
        chk("fp_full", fifo_full, 1);
        n0 = n_writes;
        grant(1); bus.recibir = 1; bus.io_data = 8'h55;
        tick();
        bus.recibir = 0;
        chk("fp_no_ovf", overflow, 0);
        chk("fp_still_full", fifo_full, 1);
        wait_idle(50);
        chk("fp_nwr", n_writes - n0, 5);
        chk("fp_last_data", last_wdata, 8'h55);
        grant(0);

        // Address wrap with a suspended grant between writes
        n0 = n_writes;
        cfg(8'hFF, 8'd2);
        push(8'h21); push(8'h22);
        grant(1);
        wait_we(20);
        chk("wrap_first_addr", bus.bus_addr, 8'hFF);
        bus.sel = 0;
        tick(5);
        chk("wrap_suspended_nwr", n_writes - n0, 1);
        bus.sel = 1;
        wait_idle(50);
        chk("wrap_nwr", n_writes - n0, 2);
        chk("wrap_second_addr", last_waddr, 8'h00);
        grant(0);

        // Zero-length descriptor
        n0 = n_writes;
        cfg(8'h50, 8'd0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        tick();
        chk("zero_done_drop", done, 0);
        chk("zero_nwr", n_writes - n0, 0);

        // Descriptor write while busy is ignored
        n0 = n_writes;
        cfg(8'h20, 8'd2);
        cfg(8'h80, 8'd7);
        push(8'h31); push(8'h32);
        grant(1);
        wait_idle(50);
        chk("busy_cfg_nwr", n_writes - n0, 2);
        chk("busy_cfg_addr", last_waddr, 8'h21);
        grant(0);

        // Reset asserted during a WRITE cycle
        cfg(8'h60, 8'd3);
        push(8'h41); push(8'h42); push(8'h43);
        grant(1);
        wait_we(20);
        rst_n = 0;
        #1;
        chk("rstw_we", bus.bus_we, 0);
        chk("rstw_done", done, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_empty", fifo_empty, 1);
        grant(0);
        tick(2);
        rst_n = 1;
        tick(4);
        chk("rstw_no_done", done, 0);

        // Randomized traffic
        for (int d = 0; d < 16; d++) begin
            wait_idle(100);
            cfg(8'($urandom), 8'($urandom_range(1, 6)));
            for (int k = 0; k < 600 && (active || done_prev); k++) begin
                bus.recibir = ($urandom_range(0, 1) == 1);
                bus.io_data = 8'($urandom);
                bus.enviar  = ($urandom_range(0, 9) < 7);
                bus.sel     = ($urandom_range(0, 9) < 7);
                cfg_we      = ($urandom_range(0, 19) == 0);
                cfg_base    = 8'($urandom);
                cfg_count   = 8'($urandom_range(0, 4));
                tick();
            end
            cfg_we = 0; bus.recibir = 0; grant(1);
            wait_idle(200);
            grant(0);
        end
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
